// File: rtl/div_rr_sched_pkg.sv
// div_sched_pkg: shared definitions for the round-robin divider scheduler.
//   state_t         scheduler FSM states
//   DEFAULT_TIMEOUT default watchdog limit, in cycles spent in WAIT
//   id_w()          width of a requester index for M requesters
package div_sched_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      ABORT = 3'd4
   } state_t;

   localparam int DEFAULT_TIMEOUT = 64;

   // At least one bit, so that a degenerate M still gives a legal vector.
   function automatic int id_w(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/div_rr_sched_if.sv
// div_rr_sched_if: every signal between the scheduler, its requesters
// and the shared divider.
//   requester side : req_valid/req_dividend/req_divisor in, req_ready out,
//                    resp_valid/resp_id/resp_quotient/resp_err out
//   divider side   : div_start/div_dividend/div_divisor/div_rst out,
//                    div_busy/div_done/div_quotient in
//   status         : sched_busy
// Modport slave is the scheduler; master is its environment.
interface div_rr_sched_if
   import div_sched_pkg::*;
#(
   parameter int N = 16,
   parameter int M = 4
);
   localparam int ID_W = id_w(M);

   logic [M-1:0]   req_valid;
   logic [M*N-1:0] req_dividend;
   logic [M*N-1:0] req_divisor;
   logic [M-1:0]   req_ready;
   logic           resp_valid;
   logic [ID_W-1:0] resp_id;
   logic [N-1:0]   resp_quotient;
   logic           resp_err;
   logic           div_start;
   logic [N-1:0]   div_dividend;
   logic [N-1:0]   div_divisor;
   logic           div_rst;
   logic           div_busy;
   logic           div_done;
   logic [N-1:0]   div_quotient;
   logic           sched_busy;

   modport slave (
      input  req_valid, req_dividend, req_divisor,
      input  div_busy, div_done, div_quotient,
      output req_ready, resp_valid, resp_id, resp_quotient, resp_err,
      output div_start, div_dividend, div_divisor, div_rst, sched_busy
   );

   modport master (
      output req_valid, req_dividend, req_divisor,
      output div_busy, div_done, div_quotient,
      input  req_ready, resp_valid, resp_id, resp_quotient, resp_err,
      input  div_start, div_dividend, div_divisor, div_rst, sched_busy
   );

endinterface

// File: rtl/div_rr_sched_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority arbiter.
//   req       M-bit request vector
//   ptr       index with highest priority (must be < M)
//   grant     one-hot grant of the first request at or after ptr, mod M
//   grant_id  index of that grant
//   grant_any at least one request present
module rr_arbiter #(
   parameter int M    = 4,
   parameter int ID_W = 2
) (
   input  logic [M-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [M-1:0]    grant,
   output logic [ID_W-1:0] grant_id,
   output logic            grant_any
);

   int idx;

   // Scan from the farthest offset back to ptr so the closest request
   // is the one written last and therefore wins.
   always_comb begin
      grant_id  = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = M - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= M) idx = idx - M;
         if (req[idx]) begin
            grant_any = 1'b1;
            grant_id  = ID_W'(idx);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < M; gi++) begin : g_onehot
         assign grant[gi] = grant_any && (grant_id == ID_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/div_rr_sched.sv
// div_rr_sched: shares one divider among M requesters in round-robin order.
// One request is accepted at a time; its operands are latched and held on
// the divider inputs, the start/done handshake is sequenced, and the
// quotient is returned tagged with the requester index. A watchdog aborts
// and resets the divider if done does not arrive within TIMEOUT cycles.
//   clk, rst  clock and asynchronous active-high reset
//   bus       div_rr_sched_if.slave (requester, response and divider signals)
module div_rr_sched
   import div_sched_pkg::*;
#(
   parameter int N       = 16,
   parameter int M       = 4,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic           clk,
   input  logic           rst,
   div_rr_sched_if.slave  bus
);

   localparam int ID_W = id_w(M);
   localparam int TW   = $clog2(TIMEOUT + 1);

   state_t          state_reg, state_next;
   logic [ID_W-1:0] rr_ptr_reg, id_reg, grant_id;
   logic [M-1:0]    grant;
   logic            grant_any;
   logic [TW-1:0]   timer_reg;
   logic [N-1:0]    dividend_reg, divisor_reg, quotient_reg;
   logic            err_reg;
   logic            hold_reg;     // high for the first cycle after reset release
   logic            accept;
   logic            timeout_hit;
   logic [M-1:0]    req_ready_c;
   logic            unused_busy;

   // Busy is informational only: done alone terminates WAIT, because the
   // divide-by-zero path reports done without ever raising busy.
   assign unused_busy = bus.div_busy;

   rr_arbiter #(.M(M), .ID_W(ID_W)) u_arb (
      .req       (bus.req_valid),
      .ptr       (rr_ptr_reg),
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_any (grant_any)
   );

   assign accept      = (state_reg == IDLE) && !hold_reg && grant_any;
   assign timeout_hit = (timer_reg == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         rr_ptr_reg   <= '0;
         id_reg       <= '0;
         timer_reg    <= '0;
         dividend_reg <= '0;
         divisor_reg  <= '0;
         quotient_reg <= '0;
         err_reg      <= 1'b0;
         hold_reg     <= 1'b1;
      end else begin
         hold_reg  <= 1'b0;
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  id_reg       <= grant_id;
                  dividend_reg <= bus.req_dividend[int'(grant_id)*N +: N];
                  divisor_reg  <= bus.req_divisor[int'(grant_id)*N +: N];
               end
            end
            ISSUE: timer_reg <= '0;
            WAIT: begin
               timer_reg <= timer_reg + 1'b1;
               if (bus.div_done) begin
                  quotient_reg <= bus.div_quotient;
                  err_reg      <= 1'b0;
               end else if (timeout_hit) begin
                  quotient_reg <= '0;
                  err_reg      <= 1'b1;
               end
            end
            RESP: rr_ptr_reg <= (id_reg == ID_W'(M - 1)) ? '0 : id_reg + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next  = state_reg;
      req_ready_c = '0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next  = ISSUE;
               req_ready_c = grant;
            end
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (bus.div_done)     state_next = RESP;
            else if (timeout_hit) state_next = ABORT;
         end
         ABORT: state_next = RESP;
         RESP:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign bus.req_ready     = req_ready_c;
   assign bus.resp_valid    = (state_reg == RESP);
   assign bus.resp_id       = (state_reg == RESP) ? id_reg : '0;
   assign bus.resp_quotient = quotient_reg;
   assign bus.resp_err      = (state_reg == RESP) && err_reg;
   assign bus.div_start     = (state_reg == ISSUE);
   assign bus.div_dividend  = dividend_reg;
   assign bus.div_divisor   = divisor_reg;
   // Held through reset and the post-reset cycle, and pulsed during ABORT.
   assign bus.div_rst       = hold_reg || (state_reg == ABORT);
   assign bus.sched_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_div_rr_sched.sv
// tb_div_rr_sched: bench for div_rr_sched with a behavioural divider that
// can be switched into a never-done stub for the watchdog sequence.
module tb_div_rr_sched;
   import div_sched_pkg::*;

   localparam int N       = 16;
   localparam int M       = 4;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   div_rr_sched_if #(.N(N), .M(M)) bus ();

   div_rr_sched #(.N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- requesters ----------------
   logic [M-1:0]        rv     = '0;
   logic [M-1:0]        sticky = '0;
   logic signed [N-1:0] ra [M];
   logic signed [N-1:0] rb [M];

   assign bus.req_valid = rv;
   generate
      for (genvar gi = 0; gi < M; gi++) begin : g_pack
         assign bus.req_dividend[gi*N +: N] = ra[gi];
         assign bus.req_divisor[gi*N +: N]  = rb[gi];
      end
   endgenerate

   // ---------------- behavioural divider ----------------
   logic         dv_busy = 1'b0;
   logic         dv_done = 1'b0;
   logic [N-1:0] dv_q    = '0;
   logic [N-1:0] dv_res  = '0;
   int           dv_cnt  = 0;
   bit           stub_mode = 1'b0;

   assign bus.div_busy     = dv_busy;
   assign bus.div_done     = dv_done;
   assign bus.div_quotient = dv_q;

   always @(posedge clk) begin
      if (bus.div_rst) begin
         dv_busy <= 1'b0;
         dv_done <= 1'b0;
         dv_cnt  <= 0;
      end else begin
         dv_done <= 1'b0;
         if (dv_cnt == 1) begin
            dv_done <= 1'b1;
            dv_busy <= 1'b0;
            dv_q    <= dv_res;
            dv_cnt  <= 0;
         end else if (dv_cnt > 1) begin
            dv_cnt <= dv_cnt - 1;
         end else if (bus.div_start) begin
            if (stub_mode) begin
               dv_busy <= 1'b1;
            end else if (bus.div_divisor == '0) begin
               dv_res <= '0;
               dv_cnt <= 1;
            end else begin
               dv_res  <= N'(int'($signed(bus.div_dividend)) / int'($signed(bus.div_divisor)));
               dv_busy <= 1'b1;
               dv_cnt  <= 10;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   typedef struct {
      int id;
      int a;
      int b;
      int q;
      int err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   mon_g;
   int   resp_log[$];
   int   q_log[$];
   int   exp_ptr = 0, cyc = 0, accept_cyc = 0, start_cyc = 0;
   int   resp_count = 0, drst_pulses = 0, drst_run = 0;
   int   last_id = 0, last_q = 0, last_err = 0;
   int   chk_acc_lat = -1, chk_start_lat = -1;
   logic prev_start = 1'b0, prev_resp = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         sb.delete();
         exp_ptr    = 0;
         prev_start = 1'b0;
         prev_resp  = 1'b0;
         drst_run   = 0;
      end else begin
         if (bus.div_rst) begin
            drst_run++;
         end else if (drst_run > 0) begin
            check("div_rst_width", drst_run, 1);
            drst_pulses++;
            drst_run = 0;
         end
         if (bus.req_ready != '0) begin
            mon_g = -1;
            for (int k = M - 1; k >= 0; k--)
               if (rv[(exp_ptr + k) % M]) mon_g = (exp_ptr + k) % M;
            check("grant", int'(bus.req_ready), (mon_g < 0) ? 0 : (1 << mon_g));
            if (mon_g >= 0) begin
               mon_e.id  = mon_g;
               mon_e.a   = ra[mon_g];
               mon_e.b   = rb[mon_g];
               mon_e.err = stub_mode ? 1 : 0;
               mon_e.q   = (stub_mode || rb[mon_g] == 0) ? 0 : int'(ra[mon_g]) / int'(rb[mon_g]);
               sb.push_back(mon_e);
               accept_cyc = cyc;
            end
         end
         if (bus.div_start) begin
            check("div_start_width", int'(prev_start), 0);
            if (sb.size() > 0) begin
               check("div_dividend", int'($signed(bus.div_dividend)), sb[$].a);
               check("div_divisor", int'($signed(bus.div_divisor)), sb[$].b);
            end
            start_cyc = cyc;
         end
         if (bus.resp_valid) begin
            check("resp_width", int'(prev_resp), 0);
            if (sb.size() == 0) begin
               check("unexpected_resp", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               check("resp_id", int'(bus.resp_id), mon_e.id);
               check("resp_quotient", int'($signed(bus.resp_quotient)), mon_e.q);
               check("resp_err", int'(bus.resp_err), mon_e.err);
               check("sched_busy_resp", int'(bus.sched_busy), 1);
               if (chk_acc_lat >= 0)   check("lat_from_accept", cyc - accept_cyc, chk_acc_lat);
               if (chk_start_lat >= 0) check("lat_from_start", cyc - start_cyc, chk_start_lat);
               exp_ptr  = (mon_e.id + 1) % M;
               last_id  = int'(bus.resp_id);
               last_q   = int'($signed(bus.resp_quotient));
               last_err = int'(bus.resp_err);
               resp_log.push_back(last_id);
               q_log.push_back(last_q);
               resp_count++;
            end
         end
         prev_start = bus.div_start;
         prev_resp  = bus.resp_valid;
      end
   end

   // ---------------- driver tasks ----------------
   // One clock: sample acceptance at the falling edge, then drop the valid
   // of each accepted non-sticky requester just after the rising edge.
   task automatic step();
      logic [M-1:0] rdy;
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      rv = rv & ~(rdy & ~sticky);
   endtask

   task automatic request(input int slot, input int a, input int b);
      ra[slot] = N'(a);
      rb[slot] = N'(b);
      rv[slot] = 1'b1;
   endtask

   task automatic wait_resp(input int n, input int budget, input string name);
      int base;
      base = resp_count;
      for (int i = 0; i < budget && resp_count < base + n; i++) step();
      check({name, "_responses"}, resp_count - base, n);
   endtask

   typedef struct {
      int slot;
      int a;
      int b;
      int q;
   } vec_t;

   vec_t tbl[6];
   int   ids_a[4], qs_a[4], ids_b[4], qs_b[4], ids_c[4];
   int   rc0, p0;

   initial begin
      tbl[0] = '{2,    100,  7,     14};
      tbl[1] = '{0,   -100,  7,    -14};
      tbl[2] = '{1, -32768,  1, -32768};
      tbl[3] = '{0,      5, -10,     0};
      tbl[4] = '{1,     -7,  2,     -3};
      tbl[5] = '{3,  32767, -1, -32767};
      ids_a = '{0, 1, 2, 3};   qs_a = '{100, 10, -9, -3};
      ids_b = '{1, 2, 3, 0};   qs_b = '{10, -9, -3, 100};
      ids_c = '{1, 3, 1, 3};
      for (int i = 0; i < M; i++) begin
         ra[i] = '0;
         rb[i] = '0;
      end

      // reset values
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", int'(bus.req_ready), 0);
      check("rst_resp_valid", int'(bus.resp_valid), 0);
      check("rst_resp_id", int'(bus.resp_id), 0);
      check("rst_resp_quotient", int'(bus.resp_quotient), 0);
      check("rst_resp_err", int'(bus.resp_err), 0);
      check("rst_div_start", int'(bus.div_start), 0);
      check("rst_div_dividend", int'(bus.div_dividend), 0);
      check("rst_div_divisor", int'(bus.div_divisor), 0);
      check("rst_div_rst", int'(bus.div_rst), 1);
      check("rst_sched_busy", int'(bus.sched_busy), 0);
      rst = 1'b0;
      #1;
      check("hold_div_rst", int'(bus.div_rst), 1);
      @(posedge clk);
      #1;
      check("released_div_rst", int'(bus.div_rst), 0);
      check("released_sched_busy", int'(bus.sched_busy), 0);

      // single requests from the vector table
      for (int i = 0; i < 6; i++) begin
         request(tbl[i].slot, tbl[i].a, tbl[i].b);
         wait_resp(1, 60, "table");
         $display("vector %0d: slot %0d %0d/%0d -> id %0d q %0d err %0d",
                  i, tbl[i].slot, tbl[i].a, tbl[i].b, last_id, last_q, last_err);
         check("tbl_id", last_id, tbl[i].slot);
         check("tbl_q", last_q, tbl[i].q);
         check("tbl_err", last_err, 0);
      end

      // all four at once, pointer at 0
      resp_log.delete();
      q_log.delete();
      request(0, 1000, 10); request(1, 50, 5); request(2, -81, 9); request(3, 7, -2);
      wait_resp(4, 200, "all4");
      for (int i = 0; i < 4; i++) begin
         $display("all4 #%0d: id %0d q %0d", i, resp_log[i], q_log[i]);
         check("all4_id", resp_log[i], ids_a[i]);
         check("all4_q", q_log[i], qs_a[i]);
      end

      // advance the pointer to 1, then a second full round
      request(0, 9, 3);
      wait_resp(1, 60, "adv");
      check("adv_q", last_q, 3);
      resp_log.delete();
      q_log.delete();
      request(0, 1000, 10); request(1, 50, 5); request(2, -81, 9); request(3, 7, -2);
      wait_resp(4, 200, "round2");
      for (int i = 0; i < 4; i++) begin
         $display("round2 #%0d: id %0d q %0d", i, resp_log[i], q_log[i]);
         check("round2_id", resp_log[i], ids_b[i]);
         check("round2_q", q_log[i], qs_b[i]);
      end

      // slots 1 and 3 hold valid continuously: grants must alternate
      resp_log.delete();
      sticky = 4'b1010;
      request(1, 40, 4); request(3, -40, 8);
      wait_resp(4, 200, "alt");
      rv = '0;
      sticky = '0;
      for (int i = 0; i < 4; i++) begin
         $display("alt #%0d: id %0d", i, resp_log[i]);
         check("alt_id", resp_log[i], ids_c[i]);
      end

      // divide by zero: quotient 0, no error, 4 cycles from accept
      chk_acc_lat = 4;
      request(0, 123, 0);
      wait_resp(1, 30, "div0");
      chk_acc_lat = -1;
      $display("div0: id %0d q %0d err %0d", last_id, last_q, last_err);
      check("div0_q", last_q, 0);
      check("div0_err", last_err, 0);

      // watchdog: divider never finishes
      stub_mode = 1'b1;
      p0 = drst_pulses;
      chk_start_lat = TIMEOUT + 2;
      request(2, 1000, 3);
      wait_resp(1, 200, "timeout");
      chk_start_lat = -1;
      stub_mode = 1'b0;
      $display("timeout: id %0d q %0d err %0d", last_id, last_q, last_err);
      check("timeout_err", last_err, 1);
      check("timeout_q", last_q, 0);
      check("abort_div_rst_pulses", drst_pulses - p0, 1);
      request(2, 1000, 3);
      wait_resp(1, 60, "after_timeout");
      $display("after timeout: id %0d q %0d err %0d", last_id, last_q, last_err);
      check("after_timeout_q", last_q, 333);
      check("after_timeout_err", last_err, 0);

      // asynchronous reset in the middle of WAIT
      request(0, 1000, 10);
      for (int i = 0; i < 20 && rv[0]; i++) step();
      check("accepted_before_rst", int'(rv[0]), 0);
      repeat (3) step();
      #2;
      rst = 1'b1;
      #1;
      check("async_sched_busy", int'(bus.sched_busy), 0);
      check("async_div_rst", int'(bus.div_rst), 1);
      check("async_resp_valid", int'(bus.resp_valid), 0);
      check("async_div_dividend", int'(bus.div_dividend), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rc0 = resp_count;
      repeat (20) step();
      check("no_resp_after_rst", resp_count - rc0, 0);
      request(1, -500, 7);
      wait_resp(1, 60, "post_rst");
      $display("post reset: id %0d q %0d err %0d", last_id, last_q, last_err);
      check("post_rst_id", last_id, 1);
      check("post_rst_q", last_q, -71);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
